// File: rtl/game_flow_ctrl.sv
`timescale 1ns/1ps
// Game flow controller for a frame-clocked shooter.
// Sequences splash, level load, play, hit/clear pauses and game over; tracks level, lives and score.
module game_flow_ctrl #(
   parameter int unsigned NE          = 8,
   parameter int unsigned NUM_LEVELS  = 5,
   parameter int unsigned LIVES       = 3,
   parameter int unsigned POINTS      = 10,
   parameter logic [7:0]  START_KEY   = 8'h28,
   parameter int unsigned CLEAR_DELAY = 120,
   parameter int unsigned HIT_DELAY   = 90
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [15:0]   keycode,
   input  logic [NE-1:0] EShipEn,
   input  logic [NE-1:0] EShipKill,
   input  logic          ShipEn,
   output logic          ResetShips,
   output logic          NewGame,
   output logic          SplashScreen,
   output logic          GameOver,
   output logic          Win,
   output logic [2:0]    CurrentLevel,
   output logic [3:0]    LivesLeft,
   output logic [15:0]   Score
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SUM_W = 33;

   typedef enum logic [2:0] {
      SPLASH = 3'd0,
      LOAD   = 3'd1,
      PLAY   = 3'd2,
      HIT    = 3'd3,
      CLEAR  = 3'd4,
      OVER   = 3'd5
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               prev_key;
   logic               key_now;
   logic               start_evt;
   logic               cnt_zero;
   logic               last_level;
   logic               no_enemies;
   logic [31:0]        kill_cnt;
   logic [SUM_W-1:0]   score_sum;
   logic [15:0]        score_nxt;

   // Event decode: start-key edge, pause expiry, kill popcount and saturating score
   always_comb begin
      key_now    = (keycode[7:0] == START_KEY) || (keycode[15:8] == START_KEY);
      start_evt  = key_now && !prev_key;
      cnt_zero   = (cnt == '0);
      last_level = (CurrentLevel == 3'(NUM_LEVELS - 1));
      no_enemies = (EShipEn == '0);
      kill_cnt   = '0;
      for (int i = 0; i < NE; i++) begin
         kill_cnt = kill_cnt + 32'(EShipKill[i]);
      end
      score_sum  = SUM_W'(Score) + SUM_W'(POINTS * kill_cnt);
      score_nxt  = (score_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : score_sum[15:0];
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= SPLASH;
      else       state <= state_nxt;
   end

   // Next-state logic; a hit outranks a simultaneous wave clear
   always_comb begin
      state_nxt = state;
      case (state)
         SPLASH, OVER: if (start_evt) state_nxt = LOAD;
         LOAD:         state_nxt = PLAY;
         PLAY: begin
            if (!ShipEn)         state_nxt = HIT;
            else if (no_enemies) state_nxt = CLEAR;
         end
         HIT:   if (cnt_zero) state_nxt = (LivesLeft == 4'd0) ? OVER : LOAD;
         CLEAR: if (cnt_zero) state_nxt = last_level ? OVER : LOAD;
         default:             state_nxt = SPLASH;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      ResetShips   = (state == LOAD) || (state == SPLASH);
      SplashScreen = (state == SPLASH);
      GameOver     = (state == OVER);
   end

   // Game datapath: score, lives, level, pause counter and start-key history
   always_ff @(posedge Clk) begin
      if (Reset) begin
         prev_key     <= 1'b0;
         NewGame      <= 1'b0;
         Win          <= 1'b0;
         CurrentLevel <= 3'd0;
         LivesLeft    <= 4'(LIVES);
         Score        <= 16'd0;
         cnt          <= '0;
      end else begin
         prev_key <= key_now;
         NewGame  <= 1'b0;
         case (state)
            SPLASH, OVER: begin
               if (start_evt) begin
                  NewGame      <= 1'b1;
                  Win          <= 1'b0;
                  CurrentLevel <= 3'd0;
                  LivesLeft    <= 4'(LIVES);
                  Score        <= 16'd0;
               end
            end
            PLAY: begin
               Score <= score_nxt;
               if (!ShipEn) begin
                  LivesLeft <= LivesLeft - 4'd1;
                  cnt       <= CNT_W'(HIT_DELAY - 1);
               end else if (no_enemies) begin
                  cnt <= CNT_W'(CLEAR_DELAY - 1);
               end
            end
            HIT: begin
               if (!cnt_zero) cnt <= cnt - CNT_W'(1);
            end
            CLEAR: begin
               if (!cnt_zero)      cnt          <= cnt - CNT_W'(1);
               else if (last_level) Win         <= 1'b1;
               else                CurrentLevel <= CurrentLevel + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
// Directed bench for game_flow_ctrl: start edge, scoring/saturation, clears, hits, final level, reset mid-pause.
module tb_game_flow_ctrl;

   localparam logic [31:0] S_SPLASH = 32'd0;
   localparam logic [31:0] S_LOAD   = 32'd1;
   localparam logic [31:0] S_PLAY   = 32'd2;
   localparam logic [31:0] S_HIT    = 32'd3;
   localparam logic [31:0] S_CLEAR  = 32'd4;
   localparam logic [31:0] S_OVER   = 32'd5;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] keycode;
   logic [7:0]  EShipEn;
   logic [7:0]  EShipKill;
   logic        ShipEn;
   logic        ResetShips;
   logic        NewGame;
   logic        SplashScreen;
   logic        GameOver;
   logic        Win;
   logic [2:0]  CurrentLevel;
   logic [3:0]  LivesLeft;
   logic [15:0] Score;

   int total = 0;
   int bad   = 0;
   int n;
   int ng;

   game_flow_ctrl dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .keycode      (keycode),
      .EShipEn      (EShipEn),
      .EShipKill    (EShipKill),
      .ShipEn       (ShipEn),
      .ResetShips   (ResetShips),
      .NewGame      (NewGame),
      .SplashScreen (SplashScreen),
      .GameOver     (GameOver),
      .Win          (Win),
      .CurrentLevel (CurrentLevel),
      .LivesLeft    (LivesLeft),
      .Score        (Score)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Counts cycles spent in state s, starting with the current one; bounded
   task automatic wait_leave(input logic [31:0] s, output int cycles);
      cycles = 0;
      while ((32'(dut.state) == s) && (cycles < 400)) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; keycode = 16'h0; ShipEn = 1'b1; EShipEn = 8'hFF; EShipKill = 8'h0;
      tick(); tick();
      check("rst_state", 32'(dut.state), S_SPLASH);
      check("rst_splash", 32'(SplashScreen), 32'd1);
      check("rst_resetships", 32'(ResetShips), 32'd1);
      check("rst_newgame", 32'(NewGame), 32'd0);
      check("rst_gameover", 32'(GameOver), 32'd0);
      check("rst_win", 32'(Win), 32'd0);
      check("rst_level", 32'(CurrentLevel), 32'd0);
      check("rst_lives", 32'(LivesLeft), 32'd3);
      check("rst_score", 32'(Score), 32'd0);
      Reset = 1'b0;
      tick();
      check("idle_splash", 32'(dut.state), S_SPLASH);

      // Start key held for 5 frames
      keycode = 16'h0028; ng = 0;
      tick(); ng += int'(NewGame);
      check("start_load", 32'(dut.state), S_LOAD);
      check("start_newgame", 32'(NewGame), 32'd1);
      check("load_resetships", 32'(ResetShips), 32'd1);
      check("load_splash", 32'(SplashScreen), 32'd0);
      tick(); ng += int'(NewGame);
      check("start_play", 32'(dut.state), S_PLAY);
      check("play_resetships", 32'(ResetShips), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); ng += int'(NewGame);
      end
      check("held_still_play", 32'(dut.state), S_PLAY);
      check("held_one_pulse", 32'(ng), 32'd1);
      keycode = 16'h0;

      // Two kills = +20
      EShipKill = 8'b0000_0101;
      tick();
      check("score_two_kills", 32'(Score), 32'd20);
      EShipKill = 8'h0;
      tick();
      check("score_hold", 32'(Score), 32'd20);

      // Level clear, kills ignored during the pause
      EShipEn = 8'h00;
      tick();
      check("clear_enter", 32'(dut.state), S_CLEAR);
      EShipEn = 8'hFF; EShipKill = 8'hFF;
      wait_leave(S_CLEAR, n);
      EShipKill = 8'h0;
      check("clear_len", 32'(n), 32'd120);
      check("clear_to_load", 32'(dut.state), S_LOAD);
      check("clear_level", 32'(CurrentLevel), 32'd1);
      check("clear_no_score", 32'(Score), 32'd20);
      tick();
      check("clear_replay", 32'(dut.state), S_PLAY);

      // Drive score to 0xFFF0, then saturate
      for (int i = 0; i < 818; i++) begin
         EShipKill = 8'hFF;
         tick();
      end
      EShipKill = 8'h3F;
      tick();
      check("score_fff0", 32'(Score), 32'h0000_FFF0);
      EShipKill = 8'h07;
      tick();
      check("score_sat", 32'(Score), 32'h0000_FFFF);
      EShipKill = 8'hFF;
      tick();
      check("score_sat_hold", 32'(Score), 32'h0000_FFFF);
      EShipKill = 8'h0;

      // Player hit
      ShipEn = 1'b0;
      tick();
      check("hit_enter", 32'(dut.state), S_HIT);
      check("hit_lives", 32'(LivesLeft), 32'd2);
      ShipEn = 1'b1;
      wait_leave(S_HIT, n);
      check("hit_len", 32'(n), 32'd90);
      check("hit_to_load", 32'(dut.state), S_LOAD);
      check("hit_level_kept", 32'(CurrentLevel), 32'd1);
      tick();
      ShipEn = 1'b0;
      tick();
      ShipEn = 1'b1;
      check("hit2_lives", 32'(LivesLeft), 32'd1);
      wait_leave(S_HIT, n);
      tick();
      check("hit2_replay", 32'(dut.state), S_PLAY);

      // Simultaneous hit and clear with one life left
      ShipEn = 1'b0; EShipEn = 8'h00;
      tick();
      check("sim_hit", 32'(dut.state), S_HIT);
      check("sim_lives", 32'(LivesLeft), 32'd0);
      check("sim_level", 32'(CurrentLevel), 32'd1);
      ShipEn = 1'b1; EShipEn = 8'hFF;
      wait_leave(S_HIT, n);
      check("sim_len", 32'(n), 32'd90);
      check("sim_over", 32'(dut.state), S_OVER);
      check("sim_gameover", 32'(GameOver), 32'd1);
      check("sim_win", 32'(Win), 32'd0);
      EShipKill = 8'hFF;
      tick();
      EShipKill = 8'h0;
      check("over_score_hold", 32'(Score), 32'h0000_FFFF);
      check("over_lives_hold", 32'(LivesLeft), 32'd0);

      // New game via the upper key slot
      keycode = 16'h2800;
      tick();
      check("ng2_load", 32'(dut.state), S_LOAD);
      check("ng2_pulse", 32'(NewGame), 32'd1);
      check("ng2_score", 32'(Score), 32'd0);
      check("ng2_lives", 32'(LivesLeft), 32'd3);
      check("ng2_level", 32'(CurrentLevel), 32'd0);
      keycode = 16'h0;
      tick();
      EShipKill = 8'h01;
      tick();
      EShipKill = 8'h0;
      check("ng2_score10", 32'(Score), 32'd10);
      ShipEn = 1'b0;
      tick();
      ShipEn = 1'b1;
      wait_leave(S_HIT, n);
      tick();
      check("ng2_lives2", 32'(LivesLeft), 32'd2);

      // Clear levels 0..3, then the final level
      for (int l = 0; l < 4; l++) begin
         EShipEn = 8'h00;
         tick();
         EShipEn = 8'hFF;
         wait_leave(S_CLEAR, n);
         check("lvl_advance", 32'(CurrentLevel), 32'(l + 1));
         tick();
      end
      EShipEn = 8'h00;
      tick();
      check("final_clear", 32'(dut.state), S_CLEAR);
      EShipEn = 8'hFF;
      wait_leave(S_CLEAR, n);
      check("final_over", 32'(dut.state), S_OVER);
      check("final_win", 32'(Win), 32'd1);
      check("final_level", 32'(CurrentLevel), 32'd4);
      check("final_score", 32'(Score), 32'd10);
      keycode = 16'h0028;
      tick();
      check("restart_score", 32'(Score), 32'd0);
      check("restart_lives", 32'(LivesLeft), 32'd3);
      check("restart_level", 32'(CurrentLevel), 32'd0);
      check("restart_win", 32'(Win), 32'd0);
      tick();
      keycode = 16'h0;
      check("restart_play", 32'(dut.state), S_PLAY);

      // Reset mid-pause, racing a fresh start edge
      EShipKill = 8'h01;
      tick();
      EShipKill = 8'h0;
      ShipEn = 1'b0;
      tick();
      ShipEn = 1'b1;
      repeat (50) tick();
      check("mid_hit", 32'(dut.state), S_HIT);
      check("mid_cnt", 32'(dut.cnt), 32'd39);
      Reset = 1'b1; keycode = 16'h0028;
      tick();
      check("mrst_state", 32'(dut.state), S_SPLASH);
      check("mrst_splash", 32'(SplashScreen), 32'd1);
      check("mrst_resetships", 32'(ResetShips), 32'd1);
      check("mrst_newgame", 32'(NewGame), 32'd0);
      check("mrst_gameover", 32'(GameOver), 32'd0);
      check("mrst_win", 32'(Win), 32'd0);
      check("mrst_level", 32'(CurrentLevel), 32'd0);
      check("mrst_lives", 32'(LivesLeft), 32'd3);
      check("mrst_score", 32'(Score), 32'd0);
      check("mrst_cnt", 32'(dut.cnt), 32'd0);
      check("mrst_prevkey", 32'(dut.prev_key), 32'd0);
      Reset = 1'b0; keycode = 16'h0;
      tick();
      check("mrst_stay", 32'(dut.state), S_SPLASH);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
